// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
// Shared definitions for the multi-channel clock-enable generator.
//   MODE_PULSE / MODE_SQUARE : encoding of the per-channel mode input.
//   div_lsb()                : low bit of channel ch's divisor inside the
//                              packed div_value bus (ch*width).
// -----------------------------------------------------------------------------
package tick_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  function automatic int unsigned div_lsb(input int unsigned ch,
                                          input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One divider channel. Counts clock edges up to the active period and emits a
// one-cycle tick at terminal count; in square mode div_clock toggles on every
// terminal count. A divisor loaded mid-period is parked in a shadow register
// and applied at the next terminal count, so a period change never produces
// a runt pulse.
//
// Ports
//   i_clock      : clock, rising edge
//   i_reset      : asynchronous active-low reset
//   i_enable     : count enable
//   i_mode       : 0 = pulse, 1 = square
//   i_restart    : synchronous phase restart (highest priority)
//   i_load       : capture i_div_value as the new divisor
//   i_div_value  : new divisor
//   o_tick       : one-cycle pulse at terminal count
//   o_div_clock  : pulse mode = tick, square mode = toggles at terminal count
//   o_pending    : a divisor waits in the shadow register
// -----------------------------------------------------------------------------
module tick_channel
  import tick_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 40000000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_mode,
  input  logic             i_restart,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div_value,
  output logic             o_tick,
  output logic             o_div_clock,
  output logic             o_pending
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_div;

  logic             w_tc;
  logic             w_square;

  // >= rather than == so a counter somehow above the period still wraps.
  assign w_tc     = (r_counter >= r_period);
  assign w_square = (i_mode == MODE_SQUARE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_counter <= '0;
      r_period  <= DEF_DIV;
      r_shadow  <= DEF_DIV;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_div     <= 1'b0;
    end else if (i_restart) begin
      r_counter <= '0;
      r_tick    <= 1'b0;
      r_div     <= 1'b0;
      r_pending <= 1'b0;
      if (i_load)         r_period <= i_div_value;
      else if (r_pending) r_period <= r_shadow;
    end else if (!i_enable) begin
      r_tick <= 1'b0;
      if (!w_square) r_div <= 1'b0;
      // While stopped there is no phase to protect: apply a parked divisor now.
      if (r_pending) begin
        r_period  <= r_shadow;
        r_counter <= '0;
        r_pending <= 1'b0;
      end
      // A load here lands in the shadow and is applied one cycle later;
      // it overrides the pending clear above.
      if (i_load) begin
        r_shadow  <= i_div_value;
        r_pending <= 1'b1;
      end
    end else if (w_tc) begin
      r_counter <= '0;
      r_tick    <= 1'b1;
      r_div     <= w_square ? ~r_div : 1'b1;
      if (i_load) begin
        r_period  <= i_div_value;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_period  <= r_shadow;
        r_pending <= 1'b0;
      end
    end else begin
      r_counter <= r_counter + ONE;
      r_tick    <= 1'b0;
      if (!w_square) r_div <= 1'b0;
      if (i_load) begin
        r_shadow  <= i_div_value;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_tick      = r_tick;
  assign o_div_clock = r_div;
  assign o_pending   = r_pending;

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// Multi-channel clock-enable generator: CHANNELS independent tick_channel
// instances sharing only clock and reset.
//
// Ports
//   clock      : clock, rising edge
//   reset      : asynchronous active-low reset
//   enable     : per-channel count enable
//   mode       : per-channel mode, 0 = pulse, 1 = square
//   restart    : per-channel synchronous phase restart
//   load       : per-channel divisor load strobe
//   div_value  : channel i divisor in [i*WIDTH +: WIDTH]
//   tick       : per-channel one-cycle terminal-count pulse
//   div_clock  : per-channel divided clock (pulse or square)
//   pending    : per-channel shadow divisor waiting
// -----------------------------------------------------------------------------
module tick_generator
  import tick_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 40000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       restart,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_value,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       div_clock,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_enable    (enable[g]),
      .i_mode      (mode[g]),
      .i_restart   (restart[g]),
      .i_load      (load[g]),
      .i_div_value (div_value[div_lsb(g, WIDTH) +: WIDTH]),
      .o_tick      (tick[g]),
      .o_div_clock (div_clock[g]),
      .o_pending   (pending[g])
    );
  end

endmodule
